// File: rtl/mdu_alu.sv
// Handshaked execute unit: single-cycle ALU ops plus iterative unsigned MUL/DIV with HI/LO result.
// Optional build macro MDU_ALU_EARLY_TERM_EN lets MUL finish once the remaining multiplier bits are zero.
module mdu_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [2:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             ovf,
   output logic             zero,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_LUI = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [2:0]           op_r;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     opnd;
   logic [WIDTH-1:0]     mq;
   logic                 accept;

   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   logic signed [WIDTH-1:0] a_s, b_s, sum_s, dif_s;
   logic [WIDTH-1:0]        sc_res;
   logic                    sc_ovf;

   assign a_s   = src_a;
   assign b_s   = src_b;
   assign sum_s = a_s + b_s;
   assign dif_s = a_s - b_s;

   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      case (alu_control)
         OP_AND: sc_res = src_a & src_b;
         OP_OR:  sc_res = src_a | src_b;
         OP_ADD: begin
            sc_res = sum_s;
            sc_ovf = add_ovf(a_s, b_s, sum_s);
         end
         OP_SUB: begin
            sc_res = dif_s;
            sc_ovf = sub_ovf(a_s, b_s, dif_s);
         end
         OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_LUI: sc_res = {src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         default: ;
      endcase
   end

   // Shift-add step: conditional add into the high half, then shift the whole accumulator right.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_acc, mul_fin;
   logic                 mul_last;

   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mq[0] ? opnd : {WIDTH{1'b0}})};
   assign mul_acc = {mul_sum, acc[WIDTH-1:1]};

`ifdef MDU_ALU_EARLY_TERM_EN
   assign mul_last = (mq[WIDTH-1:1] == '0);
   assign mul_fin  = mul_acc >> (cnt - CNT_W'(1));
`else
   assign mul_last = (cnt == CNT_W'(1));
   assign mul_fin  = mul_acc;
`endif

   // Restoring step: remainder in the high half, quotient bits shift into the low half.
   logic [WIDTH:0]       rem_sh, div_dif;
   logic [2*WIDTH-1:0]   div_acc;

   assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_dif = rem_sh - {1'b0, opnd};
   assign div_acc = div_dif[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         result      <= '0;
         result_hi   <= '0;
         ovf         <= 1'b0;
         zero        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (op_r == OP_MUL) begin
                  acc <= mul_acc;
                  mq  <= mq >> 1;
                  if (mul_last) begin
                     result      <= mul_fin[WIDTH-1:0];
                     result_hi   <= mul_fin[2*WIDTH-1:WIDTH];
                     ovf         <= |mul_fin[2*WIDTH-1:WIDTH];
                     zero        <= (mul_fin[WIDTH-1:0] == '0);
                     div_by_zero <= 1'b0;
                     cnt         <= '0;
                     state       <= DONE;
                  end
               end else begin
                  acc <= div_acc;
                  if (cnt == CNT_W'(1)) begin
                     result      <= div_acc[WIDTH-1:0];
                     result_hi   <= div_acc[2*WIDTH-1:WIDTH];
                     ovf         <= 1'b0;
                     zero        <= (div_acc[WIDTH-1:0] == '0);
                     div_by_zero <= 1'b0;
                     state       <= DONE;
                  end
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: ;
         endcase

         // A new accept overrides the DONE->IDLE drain, giving back-to-back issue.
         if (accept) begin
            op_r <= alu_control;
            if (alu_control == OP_MUL) begin
               acc   <= '0;
               mq    <= src_b;
               opnd  <= src_a;
               cnt   <= CNT_W'(WIDTH);
               state <= BUSY;
`ifdef MDU_ALU_EARLY_TERM_EN
               if (src_b == '0) begin
                  result      <= '0;
                  result_hi   <= '0;
                  ovf         <= 1'b0;
                  zero        <= 1'b1;
                  div_by_zero <= 1'b0;
                  cnt         <= '0;
                  state       <= DONE;
               end
`endif
            end else if ((alu_control == OP_DIV) && (src_b == '0)) begin
               result      <= '1;
               result_hi   <= src_a;
               ovf         <= 1'b0;
               zero        <= 1'b0;
               div_by_zero <= 1'b1;
               state       <= DONE;
            end else if (alu_control == OP_DIV) begin
               acc   <= {{WIDTH{1'b0}}, src_a};
               opnd  <= src_b;
               cnt   <= CNT_W'(WIDTH);
               state <= BUSY;
            end else begin
               result      <= sc_res;
               result_hi   <= '0;
               ovf         <= sc_ovf;
               zero        <= (sc_res == '0);
               div_by_zero <= 1'b0;
               state       <= DONE;
            end
         end
      end
   end

endmodule
